// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - asynchronous SRAM controller with parameterised read and write strobe timing
module sram_ctrl #(
   parameter int ADDR_W   = 18,
   parameter int DATA_W   = 16,
   parameter int RD_WAIT  = 2,
   parameter int WR_SETUP = 1,
   parameter int WR_PULSE = 2,
   parameter int WR_HOLD  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] ram_addr,
   inout  wire  [DATA_W-1:0] ram_data,
   output logic              ram_ce_n,
   output logic              ram_oe_n,
   output logic              ram_we_n
);
   localparam int RD_E   = (RD_WAIT  < 1) ? 1 : RD_WAIT;
   localparam int WS_E   = (WR_SETUP < 1) ? 1 : WR_SETUP;
   localparam int WP_E   = (WR_PULSE < 1) ? 1 : WR_PULSE;
   localparam int WH_E   = (WR_HOLD  < 1) ? 1 : WR_HOLD;
   localparam int MAX_RW = (RD_E > WS_E) ? RD_E : WS_E;
   localparam int MAX_PH = (WP_E > WH_E) ? WP_E : WH_E;
   localparam int MAX_E  = (MAX_RW > MAX_PH) ? MAX_RW : MAX_PH;
   localparam int CNT_W  = $clog2(MAX_E + 1);

   localparam logic [CNT_W-1:0] RD_LD = CNT_W'(RD_E - 1);
   localparam logic [CNT_W-1:0] WS_LD = CNT_W'(WS_E - 1);
   localparam logic [CNT_W-1:0] WP_LD = CNT_W'(WP_E - 1);
   localparam logic [CNT_W-1:0] WH_LD = CNT_W'(WH_E - 1);

   typedef enum logic [2:0] {IDLE, RD, WR_S, WR_P, WR_H} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              ce_n_q, ce_n_d;
   logic              oe_n_q, oe_n_d;
   logic              we_n_q, we_n_d;

   // The counter is preloaded with (phase length - 1) and each phase ends when it reads zero.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      rsp_valid_d = 1'b0;
      ce_n_d      = ce_n_q;
      oe_n_d      = oe_n_q;
      we_n_d      = we_n_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d = req_addr;
               ce_n_d = 1'b0;
               if (req_we) begin
                  wdata_d = req_wdata;
                  cnt_d   = WS_LD;
                  state_d = WR_S;
               end else begin
                  oe_n_d  = 1'b0;
                  cnt_d   = RD_LD;
                  state_d = RD;
               end
            end
         end
         RD: begin
            if (cnt_q == '0) begin
               rdata_d     = ram_data;
               rsp_valid_d = 1'b1;
               oe_n_d      = 1'b1;
               ce_n_d      = 1'b1;
               state_d     = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WR_S: begin
            if (cnt_q == '0) begin
               we_n_d  = 1'b0;
               cnt_d   = WP_LD;
               state_d = WR_P;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WR_P: begin
            if (cnt_q == '0) begin
               we_n_d  = 1'b1;
               cnt_d   = WH_LD;
               state_d = WR_H;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WR_H: begin
            if (cnt_q == '0) begin
               ce_n_d      = 1'b1;
               rsp_valid_d = 1'b1;
               state_d     = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            ce_n_d  = 1'b1;
            oe_n_d  = 1'b1;
            we_n_d  = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         ce_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         rsp_valid_q <= rsp_valid_d;
         ce_n_q      <= ce_n_d;
         oe_n_q      <= oe_n_d;
         we_n_q      <= we_n_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign busy      = ~req_ready;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;
   assign ram_addr  = addr_q;
   assign ram_ce_n  = ce_n_q;
   assign ram_oe_n  = oe_n_q;
   assign ram_we_n  = we_n_q;
   assign ram_data  = (state_q == WR_S || state_q == WR_P || state_q == WR_H) ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - randomized bench for sram_ctrl against a behavioural SRAM and memory reference
module tb_sram_ctrl;
   localparam int AW = 18;
   localparam int DW = 16;
   localparam int A_RD = 2, A_WS = 1, A_WP = 2, A_WH = 1;
   localparam int LAT_RD_A = 1 + A_RD;
   localparam int LAT_WR_A = 1 + A_WS + A_WP + A_WH;
   localparam int LAT_RD_B = 5;
   localparam int LAT_WR_B = 6;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int checks = 0;
   int failures = 0;
   int overlap_a = 0;
   int overlap_b = 0;
   logic [DW-1:0] last_rd_a = '0;

   logic          req_valid = 1'b0, req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          req_ready, rsp_valid, busy, ram_ce_n, ram_oe_n, ram_we_n;
   logic [DW-1:0] rsp_rdata;
   logic [AW-1:0] ram_addr;
   wire  [DW-1:0] ram_data;

   logic          b_req_valid = 1'b0, b_req_we = 1'b0;
   logic [AW-1:0] b_req_addr = '0;
   logic [DW-1:0] b_req_wdata = '0;
   logic          b_req_ready, b_rsp_valid, b_busy, b_ram_ce_n, b_ram_oe_n, b_ram_we_n;
   logic [DW-1:0] b_rsp_rdata;
   logic [AW-1:0] b_ram_addr;
   wire  [DW-1:0] b_ram_data;

   sram_ctrl dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .busy(busy), .ram_addr(ram_addr), .ram_data(ram_data), .ram_ce_n(ram_ce_n),
      .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
   );

   sram_ctrl #(.RD_WAIT(4), .WR_SETUP(1), .WR_PULSE(3), .WR_HOLD(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
      .req_addr(b_req_addr), .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
      .busy(b_busy), .ram_addr(b_ram_addr), .ram_data(b_ram_data), .ram_ce_n(b_ram_ce_n),
      .ram_oe_n(b_ram_oe_n), .ram_we_n(b_ram_we_n)
   );

   always #5 clk = ~clk;

   // Behavioural SRAMs: unwritten words read back a fixed address-derived pattern.
   function automatic logic [DW-1:0] sram_init(input logic [AW-1:0] a);
      return a[DW-1:0] ^ 16'hC3C3;
   endfunction

   logic [DW-1:0] mem_a [logic [AW-1:0]];
   logic [DW-1:0] mem_b [logic [AW-1:0]];
   logic [DW-1:0] ref_a [logic [AW-1:0]];
   logic [DW-1:0] rd_a, rd_b;

   always @(ram_addr or ram_oe_n or ram_ce_n)
      rd_a = mem_a.exists(ram_addr) ? mem_a[ram_addr] : sram_init(ram_addr);
   always @(b_ram_addr or b_ram_oe_n or b_ram_ce_n)
      rd_b = mem_b.exists(b_ram_addr) ? mem_b[b_ram_addr] : sram_init(b_ram_addr);
   assign ram_data   = (!ram_ce_n && !ram_oe_n) ? rd_a : {DW{1'bz}};
   assign b_ram_data = (!b_ram_ce_n && !b_ram_oe_n) ? rd_b : {DW{1'bz}};
   always @(posedge ram_we_n)   if (rst_n && !ram_ce_n)   mem_a[ram_addr] = ram_data;
   always @(posedge b_ram_we_n) if (rst_n && !b_ram_ce_n) mem_b[b_ram_addr] = b_ram_data;

   always @(negedge clk) begin
      if (!ram_we_n && !ram_oe_n) overlap_a++;
      if (!b_ram_we_n && !b_ram_oe_n) overlap_b++;
   end

   function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
      if (ref_a.exists(a)) return ref_a[a];
      return sram_init(a);
   endfunction

   task automatic drive_req(input bit sel, input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (sel) begin
         b_req_valid = v; b_req_we = we; b_req_addr = a; b_req_wdata = d;
      end else begin
         req_valid = v; req_we = we; req_addr = a; req_wdata = d;
      end
   endtask

   task automatic do_req(input bit sel, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int lat, output logic [DW-1:0] rd);
      drive_req(sel, 1'b1, we, a, d);
      @(posedge clk); #1;
      lat = 1;
      drive_req(sel, 1'($urandom_range(0, 1)), 1'($urandom), AW'($urandom), DW'($urandom));
      while (!(sel ? b_rsp_valid : rsp_valid) && lat < 60) begin
         @(posedge clk); #1;
         lat++;
         drive_req(sel, 1'b0, 1'($urandom), AW'($urandom), DW'($urandom));
      end
      drive_req(sel, 1'b0, 1'($urandom), AW'($urandom), DW'($urandom));
      rd = sel ? b_rsp_rdata : rsp_rdata;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({req_ready, busy, rsp_valid, ram_ce_n, ram_oe_n, ram_we_n} !== 6'b100111 || rsp_rdata !== '0 || ram_addr !== '0) begin
         failures++;
         $display("FAIL reset_a: ctl=%b rdata=%h addr=%h want ctl=100111 rdata=0 addr=0",
                  {req_ready, busy, rsp_valid, ram_ce_n, ram_oe_n, ram_we_n}, rsp_rdata, ram_addr);
      end
      checks++;
      if ({b_req_ready, b_busy, b_rsp_valid, b_ram_ce_n, b_ram_oe_n, b_ram_we_n} !== 6'b100111 || b_rsp_rdata !== '0 || b_ram_addr !== '0) begin
         failures++;
         $display("FAIL reset_b: ctl=%b rdata=%h addr=%h want ctl=100111 rdata=0 addr=0",
                  {b_req_ready, b_busy, b_rsp_valid, b_ram_ce_n, b_ram_oe_n, b_ram_we_n}, b_rsp_rdata, b_ram_addr);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({req_ready, busy, rsp_valid} !== 3'b100) begin
         failures++;
         $display("FAIL reset_release: ready/busy/rsp=%b want 100", {req_ready, busy, rsp_valid});
      end
   endtask

   task automatic test_write_timing();
      logic exp_ce, exp_we, exp_rv;
      drive_req(1'b0, 1'b1, 1'b1, 18'h00012, 16'hBEEF);
      @(posedge clk); #1;
      drive_req(1'b0, 1'b0, 1'($urandom), AW'($urandom), DW'($urandom));
      for (int k = 1; k <= LAT_WR_A; k++) begin
         exp_ce = (k == LAT_WR_A);
         exp_we = !(k > A_WS && k <= A_WS + A_WP);
         exp_rv = (k == LAT_WR_A);
         checks++;
         if ({ram_ce_n, ram_oe_n, ram_we_n, rsp_valid, req_ready} !== {exp_ce, 1'b1, exp_we, exp_rv, exp_rv} || ram_addr !== 18'h00012) begin
            failures++;
            $display("FAIL wr_cycle T+%0d: ce/oe/we/rsp/rdy=%b addr=%h want %b addr=00012", k,
                     {ram_ce_n, ram_oe_n, ram_we_n, rsp_valid, req_ready}, ram_addr, {exp_ce, 1'b1, exp_we, exp_rv, exp_rv});
         end
         checks++;
         if (k < LAT_WR_A) begin
            if (ram_data !== 16'hBEEF) begin
               failures++;
               $display("FAIL wr_bus_drive T+%0d: ram_data=%h want BEEF", k, ram_data);
            end
            @(posedge clk); #1;
         end else if (ram_data === 16'hBEEF) begin
            failures++;
            $display("FAIL wr_bus_release T+%0d: ram_data=%h still driven, want high-Z", k, ram_data);
         end
      end
      ref_a[18'h00012] = 16'hBEEF;
      checks++;
      if (!mem_a.exists(18'h00012) || mem_a[18'h00012] !== 16'hBEEF || rsp_rdata !== last_rd_a) begin
         failures++;
         $display("FAIL wr_commit: sram=%h rsp_rdata=%h want sram=BEEF rsp_rdata=%h",
                  mem_a.exists(18'h00012) ? mem_a[18'h00012] : 16'h0, rsp_rdata, last_rd_a);
      end
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0 || ram_addr !== 18'h00012 || busy !== 1'b0) begin
         failures++;
         $display("FAIL wr_idle_hold: rsp=%b addr=%h busy=%b want 0 00012 0", rsp_valid, ram_addr, busy);
      end
   endtask

   task automatic test_read_timing();
      logic exp_idle;
      drive_req(1'b0, 1'b1, 1'b0, 18'h00012, DW'($urandom));
      @(posedge clk); #1;
      drive_req(1'b0, 1'b0, 1'($urandom), AW'($urandom), DW'($urandom));
      for (int k = 1; k <= LAT_RD_A; k++) begin
         exp_idle = (k == LAT_RD_A);
         checks++;
         if ({ram_ce_n, ram_oe_n, ram_we_n, rsp_valid, busy} !== {exp_idle, exp_idle, 1'b1, exp_idle, !exp_idle} || ram_addr !== 18'h00012) begin
            failures++;
            $display("FAIL rd_cycle T+%0d: ce/oe/we/rsp/busy=%b addr=%h want %b", k,
                     {ram_ce_n, ram_oe_n, ram_we_n, rsp_valid, busy}, ram_addr, {exp_idle, exp_idle, 1'b1, exp_idle, !exp_idle});
         end
         if (k < LAT_RD_A) begin
            @(posedge clk); #1;
         end
      end
      checks++;
      if (rsp_rdata !== 16'hBEEF) begin
         failures++;
         $display("FAIL rd_data: rsp_rdata=%h want BEEF", rsp_rdata);
      end
      last_rd_a = 16'hBEEF;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (rsp_rdata !== 16'hBEEF || rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL rd_hold: rsp_rdata=%h rsp=%b want BEEF 0", rsp_rdata, rsp_valid);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      logic cur_we;
      logic [DW-1:0] exp_d;
      drive_req(1'b0, 1'b1, 1'b1, 18'h3FFFF, 16'hA5A5);
      for (int i = 0; i < 4; i++) begin
         cur_we = (i % 2 == 0);
         checks++;
         if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready op%0d: req_ready=%b want 1", i, req_ready);
         end
         @(posedge clk); #1;
         lat = 1;
         req_we = (i % 2 == 1);
         req_wdata = 16'h5A5A;
         while (!rsp_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
         end
         if (i == 3) req_valid = 1'b0;
         exp_d = (i < 2) ? 16'hA5A5 : 16'h5A5A;
         if (cur_we) ref_a[18'h3FFFF] = exp_d;
         else last_rd_a = exp_d;
         checks++;
         if (lat != (cur_we ? LAT_WR_A : LAT_RD_A) || (!cur_we && rsp_rdata !== exp_d)) begin
            failures++;
            $display("FAIL b2b_op%0d: latency=%0d rdata=%h want latency=%0d rdata=%h", i, lat, rsp_rdata,
                     cur_we ? LAT_WR_A : LAT_RD_A, cur_we ? last_rd_a : exp_d);
         end
      end
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL b2b_end: rsp=%b ready=%b want 0 1", rsp_valid, req_ready);
      end
   endtask

   task automatic test_random();
      int lat, gap;
      logic we;
      logic [AW-1:0] a;
      logic [DW-1:0] d, rd, exp;
      for (int n = 0; n < 40; n++) begin
         we = 1'($urandom_range(0, 1));
         a = AW'($urandom_range(1, 16));
         d = DW'($urandom);
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
         end
         do_req(1'b0, we, a, d, lat, rd);
         if (we) begin
            ref_a[a] = d;
            checks++;
            if (lat != LAT_WR_A || rd !== last_rd_a || ram_addr !== a) begin
               failures++;
               $display("FAIL rand_wr%0d: latency=%0d rdata=%h addr=%h want %0d %h %h", n, lat, rd, ram_addr, LAT_WR_A, last_rd_a, a);
            end
         end else begin
            exp = ref_read(a);
            last_rd_a = exp;
            checks++;
            if (lat != LAT_RD_A || rd !== exp || ram_addr !== a) begin
               failures++;
               $display("FAIL rand_rd%0d: latency=%0d rdata=%h addr=%h want %0d %h %h", n, lat, rd, ram_addr, LAT_RD_A, exp, a);
            end
         end
      end
   endtask

   task automatic test_reset_mid_write();
      int seen, lat;
      logic [DW-1:0] d, rd;
      drive_req(1'b0, 1'b1, 1'b1, 18'h2AAAA, 16'h1234);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (ram_we_n !== 1'b0) begin
         failures++;
         $display("FAIL abort_in_pulse: ram_we_n=%b want 0", ram_we_n);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({ram_ce_n, ram_oe_n, ram_we_n, rsp_valid, req_ready, busy} !== 6'b111010) begin
         failures++;
         $display("FAIL abort_strobes: ce/oe/we/rsp/rdy/busy=%b want 111010", {ram_ce_n, ram_oe_n, ram_we_n, rsp_valid, req_ready, busy});
      end
      seen = 0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         if (rsp_valid) seen++;
      end
      checks++;
      if (seen != 0 || rsp_rdata !== '0 || ram_addr !== '0) begin
         failures++;
         $display("FAIL abort_no_rsp: rsp_pulses=%0d rdata=%h addr=%h want 0 0 0", seen, rsp_rdata, ram_addr);
      end
      rst_n = 1'b1;
      last_rd_a = '0;
      @(posedge clk); #1;
      d = DW'($urandom);
      do_req(1'b0, 1'b1, 18'h00009, d, lat, rd);
      ref_a[18'h00009] = d;
      checks++;
      if (lat != LAT_WR_A) begin
         failures++;
         $display("FAIL abort_recover_wr: latency=%0d want %0d", lat, LAT_WR_A);
      end
      do_req(1'b0, 1'b0, 18'h00009, DW'($urandom), lat, rd);
      last_rd_a = d;
      checks++;
      if (lat != LAT_RD_A || rd !== d) begin
         failures++;
         $display("FAIL abort_recover_rd: latency=%0d rdata=%h want %0d %h", lat, rd, LAT_RD_A, d);
      end
   endtask

   task automatic test_slow_timing();
      int lat;
      logic [DW-1:0] d, rd;
      d = DW'($urandom);
      do_req(1'b1, 1'b1, 18'h00155, d, lat, rd);
      checks++;
      if (lat != LAT_WR_B || rd !== '0) begin
         failures++;
         $display("FAIL slow_wr: latency=%0d rdata=%h want %0d 0000", lat, rd, LAT_WR_B);
      end
      do_req(1'b1, 1'b0, 18'h00155, DW'($urandom), lat, rd);
      checks++;
      if (lat != LAT_RD_B || rd !== d) begin
         failures++;
         $display("FAIL slow_rd: latency=%0d rdata=%h want %0d %h", lat, rd, LAT_RD_B, d);
      end
      do_req(1'b1, 1'b0, 18'h00156, DW'($urandom), lat, rd);
      checks++;
      if (lat != LAT_RD_B || rd !== sram_init(18'h00156)) begin
         failures++;
         $display("FAIL slow_rd_blank: latency=%0d rdata=%h want %0d %h", lat, rd, LAT_RD_B, sram_init(18'h00156));
      end
   endtask

   task automatic test_exclusive();
      checks++;
      if (overlap_a != 0 || overlap_b != 0) begin
         failures++;
         $display("FAIL oe_we_overlap: cycles a=%0d b=%0d want 0 0", overlap_a, overlap_b);
      end
   endtask

   initial begin
      test_reset();
      test_write_timing();
      test_read_timing();
      test_back_to_back();
      test_random();
      test_reset_mid_write();
      test_slow_timing();
      test_exclusive();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
